// File: rtl/seq_pattern_tx_pkg.sv
// Shared definitions for the serial pattern transmitter.
//
// Contents:
//   state_t        - FSM state encoding (IDLE=00, SHIFT=01, GAP=10)
//   DEF_PAT_W      - default pattern width; also used by the detector bench
//   DEF_CNT_W      - default repeat-count width
//   DEF_GAP        - default idle cycles between repeats
//   max_int        - helper for sizing counters from several parameters
package seq_pattern_tx_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_SHIFT = 2'b01,
      S_GAP   = 2'b10
   } state_t;

   localparam int DEF_PAT_W = 4;
   localparam int DEF_CNT_W = 4;
   localparam int DEF_GAP   = 1;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/seq_pattern_tx_down_cnt.sv
// Loadable down-counter used by the pattern transmitter.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset (count cleared to 0)
//   load     in   load load_val this cycle (takes priority over dec)
//   load_val in   value to load, W bits
//   dec      in   decrement by one; holds at 0 instead of wrapping
//   count    out  current count, W bits
//   zero     out  count is 0
module seq_down_cnt
   import seq_pattern_tx_pkg::*;
#(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic [W-1:0] count,
   output logic         zero
);

   // Load wins over decrement; a decrement at zero is dropped so the
   // counter never wraps around.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: drives the single-bit stream x consumed by
// the sequence detector. Captures a PAT_W-bit pattern and a repeat count on
// an accepted start, then shifts the pattern out MSB-first reps times, with
// GAP idle cycles between repeats.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start    in   transfer request, only looked at while idle
//   pattern  in   PAT_W bits to send, MSB first
//   reps     in   number of repeats (0 = no bits, just a done pulse)
//   x        out  serial bit, 0 whenever x_valid is 0
//   x_valid  out  x carries a pattern bit this cycle
//   busy     out  transfer in progress
//   done     out  one-cycle pulse after the last bit
module seq_pattern_tx
   import seq_pattern_tx_pkg::*;
#(
   parameter int PAT_W = DEF_PAT_W,
   parameter int CNT_W = DEF_CNT_W,
   parameter int GAP   = DEF_GAP
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [PAT_W-1:0] pattern,
   input  logic [CNT_W-1:0] reps,
   output logic             x,
   output logic             x_valid,
   output logic             busy,
   output logic             done
);

   // The bit counter is reused to time the idle gap, so it is sized for
   // whichever of the two needs more bits.
   localparam int BIT_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
   localparam int GAP_W = max_int(1, $clog2(GAP + 1));
   localparam int CW    = max_int(BIT_W, GAP_W);

   localparam logic [CW-1:0] BIT_LOAD = CW'(PAT_W - 1);
   localparam logic [CW-1:0] GAP_LOAD = CW'((GAP > 0) ? (GAP - 1) : 0);

   state_t           state_q, state_d;
   logic [PAT_W-1:0] shift_q, shift_d;
   logic [PAT_W-1:0] pat_q, pat_d;
   logic             x_q, x_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             bit_load, bit_dec, bit_zero;
   logic [CW-1:0]    bit_val, bit_count;
   logic             rem_load, rem_dec, rem_zero;
   logic [CNT_W-1:0] rem_count;

   // Bits still to send in the current repeat, or idle cycles left in a gap.
   seq_down_cnt #(.W(CW)) u_bit_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (bit_load),
      .load_val (bit_val),
      .dec      (bit_dec),
      .count    (bit_count),
      .zero     (bit_zero)
   );

   // Repeats still to send, including the one in progress.
   seq_down_cnt #(.W(CNT_W)) u_rem_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (rem_load),
      .load_val (reps),
      .dec      (rem_dec),
      .count    (rem_count),
      .zero     (rem_zero)
   );

   // All outputs come straight from flops; the combinational block below
   // computes what they must show in the following cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         shift_q <= '0;
         pat_q   <= '0;
         x_q     <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         pat_q   <= pat_d;
         x_q     <= x_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state and next-output logic. x_q holds the bit on the wire now;
   // shift_q holds the bits still to come, MSB aligned. Starting a repeat
   // (from IDLE, GAP or back-to-back) therefore puts the pattern MSB on x
   // directly and loads the rest into the shift register.
   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      pat_d    = pat_q;
      x_d      = 1'b0;
      valid_d  = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      bit_load = 1'b0;
      bit_val  = BIT_LOAD;
      bit_dec  = 1'b0;
      rem_load = 1'b0;
      rem_dec  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (reps != '0) begin
                  pat_d    = pattern;
                  shift_d  = pattern << 1;
                  x_d      = pattern[PAT_W-1];
                  valid_d  = 1'b1;
                  busy_d   = 1'b1;
                  bit_load = 1'b1;
                  rem_load = 1'b1;
                  state_d  = S_SHIFT;
               end else begin
                  done_d = 1'b1;
               end
            end
         end

         S_SHIFT: begin
            if (!bit_zero) begin
               x_d     = shift_q[PAT_W-1];
               shift_d = shift_q << 1;
               valid_d = 1'b1;
               busy_d  = 1'b1;
               bit_dec = 1'b1;
            end else begin
               // Last bit of this repeat is on the wire now. rem_zero
               // cannot be set here in normal operation; it only stops a
               // corrupted count from running away.
               rem_dec = 1'b1;
               if ((rem_count == CNT_W'(1)) || rem_zero) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else if (GAP == 0) begin
                  shift_d  = pat_q << 1;
                  x_d      = pat_q[PAT_W-1];
                  valid_d  = 1'b1;
                  busy_d   = 1'b1;
                  bit_load = 1'b1;
               end else begin
                  busy_d   = 1'b1;
                  bit_load = 1'b1;
                  bit_val  = GAP_LOAD;
                  state_d  = S_GAP;
               end
            end
         end

         S_GAP: begin
            busy_d = 1'b1;
            if (bit_count == '0) begin
               shift_d  = pat_q << 1;
               x_d      = pat_q[PAT_W-1];
               valid_d  = 1'b1;
               bit_load = 1'b1;
               state_d  = S_SHIFT;
            end else begin
               bit_dec = 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign x       = x_q;
   assign x_valid = valid_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule
